pc_fetch_sequencer: RTL and testbench

//  Owns the PC register and sequences instruction fetch for the CPU. Each cycle it selects the next PC from four sources:
//   - PC+4 (32-bit carry-lookahead add)
//   - branch target
//   - jump target
//   - register-jump target

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/next_pc_sel.sv | 46 ++++
 rtl/pc_fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: fetch FSM states, reset/exception
// vectors, address-field widths, and the 32-bit carry-lookahead adder.
package cpu_pkg;

    localparam int ADDR_W = 32;
    localparam int OFF_W  = 16;
    localparam int JIDX_W = 26;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [ADDR_W-1:0] EXC_VECTOR_DEF = 32'h0000_4180;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } fetch_state_e;

    // Two-level lookahead: eight 4-bit groups, group carries chained, bit carries per group.
    function automatic logic [31:0] cla_add32(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] g;
        logic [31:0] p;
        logic [31:0] c;
        logic [7:0]  gg;
        logic [7:0]  gp;
        logic [7:0]  gc;
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        return p ^ c;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection (jr > j > taken branch > PC+4) and
// misaligned register-jump detection.
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_br_taken,
    input  logic [OFF_W-1:0]  i_br_off,
    input  logic              i_j,
    input  logic [JIDX_W-1:0] i_j_idx,
    input  logic              i_jr,
    input  logic [ADDR_W-1:0] i_jr_addr,
    output logic [ADDR_W-1:0] o_pcadd4,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_misaligned
);

    logic [ADDR_W-1:0] w_pcadd4;
    logic [ADDR_W-1:0] w_br_disp;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_j_target;

    assign w_pcadd4    = cla_add32(i_pc, 32'd4);
    assign w_br_disp   = {{(ADDR_W-OFF_W-2){i_br_off[OFF_W-1]}}, i_br_off, 2'b00};
    assign w_br_target = cla_add32(w_pcadd4, w_br_disp);
    assign w_j_target  = {w_pcadd4[ADDR_W-1:ADDR_W-4], i_j_idx, 2'b00};

    // Only a register target can be misaligned; branch/jump targets are word-built.
    always_comb begin
        o_next_pc    = w_pcadd4;
        o_misaligned = 1'b0;
        if (i_jr) begin
            o_next_pc    = i_jr_addr;
            o_misaligned = |i_jr_addr[1:0];
        end else if (i_j) begin
            o_next_pc = w_j_target;
        end else if (i_br_taken) begin
            o_next_pc = w_br_target;
        end else begin
            o_next_pc = w_pcadd4;
        end
    end

    assign o_pcadd4 = w_pcadd4;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register and fetch FSM: FETCH -> WAIT -> ISSUE, with imem req/ack handshake,
// wait timeout and misaligned-redirect exceptions vectored to EXC_VECTOR.
module pc_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int                MAX_WAIT   = 8
)(
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] instr_o,
    output logic              instr_valid,
    input  logic              stall_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pcadd4_o,
    input  logic              br_taken_i,
    input  logic [OFF_W-1:0]  br_off_i,
    input  logic              j_i,
    input  logic [JIDX_W-1:0] j_idx_i,
    input  logic              jr_i,
    input  logic [ADDR_W-1:0] jr_addr_i,
    output logic              exc_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    fetch_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_instr, w_instr_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_req, w_req_nxt;
    logic              r_exc, w_exc_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] w_pcadd4;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_misaligned;

    next_pc_sel u_next_pc_sel (
        .i_pc         (r_pc),
        .i_br_taken   (br_taken_i),
        .i_br_off     (br_off_i),
        .i_j          (j_i),
        .i_j_idx      (j_idx_i),
        .i_jr         (jr_i),
        .i_jr_addr    (jr_addr_i),
        .o_pcadd4     (w_pcadd4),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_misaligned)
    );

    // Next-state logic; exc is a single-cycle pulse, so it defaults low every cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        w_req_nxt   = r_req;
        w_exc_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            FETCH: begin
                w_req_nxt   = 1'b1;
                w_cnt_nxt   = CNT_W'(0);
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ISSUE;
                end else if (r_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    w_exc_nxt   = 1'b1;
                    w_pc_nxt    = EXC_VECTOR;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = FETCH;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ISSUE: begin
                if (stall_i) begin
                    w_valid_nxt = 1'b1;
                end else if (w_misaligned) begin
                    w_exc_nxt   = 1'b1;
                    w_pc_nxt    = EXC_VECTOR;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = FETCH;
                end else begin
                    w_pc_nxt    = w_next_pc;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_valid_nxt = 1'b0;
                w_state_nxt = FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0000_0000;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
            r_exc   <= 1'b0;
            r_cnt   <= CNT_W'(0);
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_req   <= w_req_nxt;
            r_exc   <= w_exc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr_o     = r_instr;
    assign instr_valid = r_valid;
    assign pc_o        = r_pc;
    assign pcadd4_o    = w_pcadd4;
    assign exc_o       = r_exc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_o;
    logic        instr_valid;
    logic        stall_i;
    logic [31:0] pc_o;
    logic [31:0] pcadd4_o;
    logic        br_taken_i;
    logic [15:0] br_off_i;
    logic        j_i;
    logic [25:0] j_idx_i;
    logic        jr_i;
    logic [31:0] jr_addr_i;
    logic        exc_o;

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_o     (instr_o),
        .instr_valid (instr_valid),
        .stall_i     (stall_i),
        .pc_o        (pc_o),
        .pcadd4_o    (pcadd4_o),
        .br_taken_i  (br_taken_i),
        .br_off_i    (br_off_i),
        .j_i         (j_i),
        .j_idx_i     (j_idx_i),
        .jr_i        (jr_i),
        .jr_addr_i   (jr_addr_i),
        .exc_o       (exc_o)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        br_taken_i = 1'b0;
        br_off_i   = 16'h0000;
        j_i        = 1'b0;
        j_idx_i    = 26'h0;
        jr_i       = 1'b0;
        jr_addr_i  = 32'h0;
        stall_i    = 1'b0;
    endtask

    // Called at a negedge in ISSUE: present redirect inputs across one edge, then clear.
    task automatic issue(input logic br, input logic [15:0] off, input logic j,
                         input logic [25:0] idx, input logic jr, input logic [31:0] jaddr);
        br_taken_i = br;
        br_off_i   = off;
        j_i        = j;
        j_idx_i    = idx;
        jr_i       = jr;
        jr_addr_i  = jaddr;
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    // Wait (bounded) for req, ack it with data, and report what ISSUE looked like.
    task automatic do_fetch(input logic [31:0] data, output logic [31:0] addr,
                            output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        while (!imem_req && n < 12) begin
            @(negedge clk);
            n++;
        end
        addr = imem_addr;
        if (!imem_req) return;
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack = 1'b0;
        ok = (instr_valid === 1'b1) && (instr_o === data) && (exc_o === 1'b0)
             && (imem_req === 1'b0) && (pc_o === addr);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (pc_o !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_o, 32'h0000_3000); end
        checks++;
        if ({imem_req, instr_valid, exc_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl req/valid/exc got %b exp 000", {imem_req, instr_valid, exc_o});
        end
        checks++;
        if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        int n;
        logic ok;
        logic [31:0] exp_a [3];
        exp_a[0] = 32'h0000_3000;
        exp_a[1] = 32'h0000_3004;
        exp_a[2] = 32'h0000_3008;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) issue(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
            do_fetch(32'hA000_0000 + i, a, n, ok);
            checks++;
            if (a !== exp_a[i] || !ok) begin
                errors++; $display("FAIL seq_fetch%0d addr %h ok %b exp %h ok 1", i, a, ok, exp_a[i]);
            end
            if (i != 0) begin
                checks++;
                if (n !== 2) begin errors++; $display("FAIL seq_spacing%0d got %0d exp 2", i, n); end
            end
        end
        checks++;
        if (pcadd4_o !== 32'h0000_300C) begin errors++; $display("FAIL seq_pcadd4 got %h exp 0000300c", pcadd4_o); end
    endtask

    task automatic test_branch();
        logic [31:0] a;
        int n;
        logic ok;
        issue(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_3010);
        do_fetch(32'h1111_0001, a, n, ok);
        issue(1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 32'h0);
        do_fetch(32'h1111_0002, a, n, ok);
        checks++;
        if (a !== 32'h0000_3004 || !ok) begin errors++; $display("FAIL br_back got %h exp 00003004", a); end
        issue(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_3010);
        do_fetch(32'h1111_0003, a, n, ok);
        issue(1'b1, 16'h0002, 1'b0, 26'h0, 1'b0, 32'h0);
        do_fetch(32'h1111_0004, a, n, ok);
        checks++;
        if (a !== 32'h0000_301C || !ok) begin errors++; $display("FAIL br_fwd got %h exp 0000301c", a); end
        issue(1'b0, 16'h0100, 1'b0, 26'h0, 1'b0, 32'h0);
        do_fetch(32'h1111_0005, a, n, ok);
        checks++;
        if (a !== 32'h0000_3020 || !ok) begin errors++; $display("FAIL br_not_taken got %h exp 00003020", a); end
    endtask

    task automatic test_jump();
        logic [31:0] a;
        int n;
        logic ok;
        issue(1'b1, 16'h0040, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h0000_5000);
        do_fetch(32'h2222_0001, a, n, ok);
        checks++;
        if (a !== 32'h0000_5000 || !ok) begin errors++; $display("FAIL jr_priority got %h exp 00005000", a); end
        issue(1'b0, 16'h0, 1'b1, 26'h000_0040, 1'b1, 32'h0000_5002);
        @(negedge clk);
        checks++;
        if ({exc_o, instr_valid, imem_req} !== 3'b100 || pc_o !== 32'h0000_4180) begin
            errors++; $display("FAIL jr_misalign exc/valid/req %b pc %h exp 100 pc 00004180",
                                {exc_o, instr_valid, imem_req}, pc_o);
        end
        @(negedge clk);
        checks++;
        if (exc_o !== 1'b0) begin errors++; $display("FAIL exc_pulse_width got %b exp 0", exc_o); end
        do_fetch(32'h2222_0002, a, n, ok);
        checks++;
        if (a !== 32'h0000_4180 || n !== 0 || !ok) begin
            errors++; $display("FAIL exc_refetch addr %h n %0d exp 00004180 n 0", a, n);
        end
        issue(1'b1, 16'h0010, 1'b1, 26'h000_0C00, 1'b0, 32'h0);
        do_fetch(32'h2222_0003, a, n, ok);
        checks++;
        if (a !== 32'h0000_3000 || !ok) begin errors++; $display("FAIL j_over_br got %h exp 00003000", a); end
        issue(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hA000_0000);
        do_fetch(32'h2222_0004, a, n, ok);
        issue(1'b0, 16'h0, 1'b1, 26'h000_0010, 1'b0, 32'h0);
        do_fetch(32'h2222_0005, a, n, ok);
        checks++;
        if (a !== 32'hA000_0040 || !ok) begin errors++; $display("FAIL j_region got %h exp a0000040", a); end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        int n;
        logic ok;
        stall_i    = 1'b1;
        br_taken_i = 1'b1;
        br_off_i   = 16'h0010;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (instr_o !== 32'h2222_0005 || pc_o !== 32'hA000_0040
                || {instr_valid, imem_req, exc_o} !== 3'b100) begin
                errors++; $display("FAIL stall_hold%0d instr %h pc %h valid/req/exc %b exp 22220005 a0000040 100",
                                    c, instr_o, pc_o, {instr_valid, imem_req, exc_o});
            end
        end
        imem_ack = 1'b0;
        drive_idle();
        issue(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        do_fetch(32'h3333_0001, a, n, ok);
        checks++;
        if (a !== 32'hA000_0044 || n !== 2 || !ok) begin
            errors++; $display("FAIL stall_resume addr %h n %0d exp a0000044 n 2", a, n);
        end
    endtask

    task automatic test_timeout_wrap();
        logic [31:0] a;
        int n;
        int w;
        int cnt;
        logic ok;
        issue(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        w = 0;
        while (!imem_req && w < 12) begin @(negedge clk); w++; end
        cnt = 0;
        while (imem_req && exc_o === 1'b0 && cnt < 20) begin cnt++; @(negedge clk); end
        checks++;
        if (cnt !== 8) begin errors++; $display("FAIL timeout_wait got %0d exp 8", cnt); end
        checks++;
        if ({exc_o, instr_valid, imem_req} !== 3'b100 || pc_o !== 32'h0000_4180) begin
            errors++; $display("FAIL timeout_exc exc/valid/req %b pc %h exp 100 pc 00004180",
                                {exc_o, instr_valid, imem_req}, pc_o);
        end
        do_fetch(32'h4444_0001, a, n, ok);
        checks++;
        if (a !== 32'h0000_4180 || n !== 1 || !ok) begin
            errors++; $display("FAIL timeout_refetch addr %h n %0d exp 00004180 n 1", a, n);
        end
        issue(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
        do_fetch(32'h4444_0002, a, n, ok);
        checks++;
        if (pcadd4_o !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pcadd4 got %h exp 00000000", pcadd4_o); end
        issue(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        do_fetch(32'h4444_0003, a, n, ok);
        checks++;
        if (a !== 32'h0000_0000 || !ok) begin errors++; $display("FAIL wrap_fetch got %h exp 00000000", a); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] a;
        int n;
        int w;
        logic ok;
        issue(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        w = 0;
        while (!imem_req && w < 12) begin @(negedge clk); w++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        checks++;
        if ({instr_valid, imem_req, exc_o} !== 3'b000 || pc_o !== 32'h0000_3000) begin
            errors++; $display("FAIL rst_wait_abort valid/req/exc %b pc %h exp 000 pc 00003000",
                                {instr_valid, imem_req, exc_o}, pc_o);
        end
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr_o !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            errors++; $display("FAIL rst_late_ack valid %b instr %h req %b addr %h exp 0 0 1 00003000",
                                instr_valid, instr_o, imem_req, imem_addr);
        end
        do_fetch(32'h5555_0001, a, n, ok);
        checks++;
        if (a !== 32'h0000_3000 || !ok) begin errors++; $display("FAIL rst_refetch got %h exp 00003000", a); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_timeout_wrap();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
